kgp_run_controller: RTL and testbench
=====================================

// Module: kgp_run_controller
// PURPOSE
//  Run/boot sequencer for the single-cycle KGP RISC core. Streams a program into instruction memory through a valid/ready port.
//  Then pulses the core reset and enables the core. Supports free-run, pause and single-step.
//  Halts on a branch-to-self, an out-of-range PC, or a watchdog cycle limit.
//  Sits between the host/testbench and the core: drives the core reset, the core clock-enable and the instruction-memory write port.
// PARAMETERS
//  AW          10     instruction-memory word-address width (depth 2**AW)
//  CW          16     cycle-counter width
//  MAX_CYCLES  4096   watchdog limit on enabled core cycles per run (must be < 2**CW)
// PORTS
//  Clk         in   1     clock
//  Reset       in   1     synchronous, active-high reset
//  load_start  in   1     begin program load (sampled in IDLE)
//  load_len    in   AW+1  number of words to load, sampled with load_start
//  ld_valid    in   1     load word valid
//  ld_data     in   32    load word
//  ld_ready    out  1     controller accepts ld_data this cycle
//  run         in   1     start (IDLE/HALT: with core reset) or resume (PAUSE)
//  step        in   1     in PAUSE: enable core for exactly one cycle
//  stop        in   1     RUN -> PAUSE; LOAD -> abort to IDLE
//  pc_value    in   32    core PC (word address)
//  imem_wea    out  1     instruction-memory write enable
//  imem_addr   out  AW    instruction-memory write address
//  imem_din    out  32    instruction-memory write data
//  cpu_reset   out  1     core reset (active-high)
//  cpu_ena     out  1     core clock-enable (PC, register file, memories)
//  halted      out  1     core stopped by a halt condition
//  halt_cause  out  2     0 none, 1 self-loop, 2 watchdog, 3 PC out of range
//  cycle_count out  CW    enabled core cycles since the last CLEAR
// BEHAVIOUR
//  Reset values: state=IDLE, cpu_reset=1, cpu_ena=0, ld_ready=0, imem_wea=0, imem_addr=0, imem_din=0, halted=0, halt_cause=0, cycle_count=0.
//  Reset is synchronous: an in-flight load write is dropped and the core is held in reset.
//  All outputs are registered, except ld_ready (decoded from state).
//  States: IDLE, LOAD, CLEAR, RUN, PAUSE, HALT.
//  IDLE: cpu_reset=1.
//   - load_start with load_len!=0 -> LOAD; remaining=load_len, next address=0.
//   - load_start with load_len==0 is ignored.
//   - run -> CLEAR. If load_start and run are both high, load_start wins.
//  LOAD: ld_ready=1.
//   - Accept on ld_valid&&ld_ready. The next cycle drives imem_wea=1 for one cycle with imem_addr=word index and imem_din=ld_data.
//   - Back-to-back accepts give back-to-back writes. Address wraps modulo 2**AW.
//   - The last accept -> IDLE; its write still issues in the following cycle.
//   - stop -> IDLE; words already accepted stay written.
//  CLEAR: one cycle with cpu_reset=1, cpu_ena=0; cycle_count, halted, halt_cause and pc_prev_valid are cleared. -> RUN.
//  RUN: cpu_reset=0, cpu_ena=1. Every enabled cycle increments cycle_count and registers pc_prev=pc_value.
//  Halt checks run on every enabled cycle (RUN and step), in this priority:
//   1. pc_value[31:AW]!=0 -> cause 3.
//   2. pc_prev_valid && pc_value==pc_prev -> cause 1.
//   3. cycle_count==MAX_CYCLES-1 -> cause 2.
//   A hit -> HALT: cpu_ena=0 from the next cycle, halted=1, halt_cause latched.
//  stop in RUN with no halt hit -> PAUSE (cpu_ena=0 next cycle). A halt hit beats stop.
//  PAUSE: cpu_reset=0, cpu_ena=0.
//   - step -> cpu_ena=1 for exactly one cycle (stay PAUSE); counting and halt checks apply.
//   - run -> RUN, without core reset. If run and step are both high, run wins.
//   - step while a step cycle is active is ignored.
//  HALT: cpu_ena=0, cpu_reset=0 (core state stays observable).
//   - run -> CLEAR (restart from PC 0). load_start -> LOAD (halted cleared). step and stop are ignored.
//  cycle_count saturates at 2**CW-1.
// STRUCTURE
//  Package kgp_ctrl_pkg holds:
//   - state enum (IDLE=0, LOAD=1, CLEAR=2, RUN=3, PAUSE=4, HALT=5)
//   - halt-cause constants (HC_NONE, HC_SELF, HC_WDOG, HC_RANGE)
//  Sub-module kgp_imem_loader owns the LOAD handshake, remaining-count, address counter and registered write port.
//  Its interfaces are start/len/abort in and done out.
// TESTING
//  1. Load 4 words 0xA0..0xA3 with ld_valid held high:
//     -> imem_wea high for 4 consecutive cycles, addr 0..3, data in order; state returns to IDLE.
//  2. Load with ld_valid toggled every other cycle, then stop after 2 accepts:
//     -> only addr 0,1 written; state=IDLE.
//  3. run with pc_value sequence 0,1,2,3,3:
//     -> cpu_reset one cycle, then halted=1, halt_cause=1, cycle_count=5, cpu_ena=0.
//  4. MAX_CYCLES=8, pc_value incrementing:
//     -> halt_cause=2 with cycle_count=8; assert run again -> CLEAR pulse, cycle_count=0.
//  5. stop in RUN, then 3 step pulses, then run and step together:
//     -> exactly 3 single-cycle cpu_ena pulses, count +3, then RUN resumes without cpu_reset.
//  6. Reset asserted mid-LOAD and mid-RUN; separately pc_value=0x400 with AW=10:
//     -> next cycle all outputs at reset values; PC case halts with halt_cause=3.

Source files
------------

// File: rtl/kgp_ctrl_pkg.sv
// rtl/kgp_ctrl_pkg.sv - shared state encoding and halt-cause codes for the KGP run controller
package kgp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_RUN   = 3'd3,
        ST_PAUSE = 3'd4,
        ST_HALT  = 3'd5
    } ctrl_state_t;

    localparam logic [1:0] HC_NONE  = 2'd0;
    localparam logic [1:0] HC_SELF  = 2'd1;
    localparam logic [1:0] HC_WDOG  = 2'd2;
    localparam logic [1:0] HC_RANGE = 2'd3;

endpackage

// File: rtl/kgp_imem_loader.sv
// rtl/kgp_imem_loader.sv - program-load handshake and registered instruction-memory write port
module kgp_imem_loader
    import kgp_ctrl_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          abort,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    output logic          ld_ready,
    output logic          done,
    output logic          imem_wea,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_din
);

    localparam logic [AW:0] LAST_WORD = (AW+1)'(1);

    logic          busy;
    logic [AW:0]   remaining;
    logic [AW-1:0] addr_next;
    logic          accept;

    assign ld_ready = busy;
    assign accept   = busy && ld_valid;
    // A word accepted in the same cycle as abort is still written.
    assign done     = busy && (abort || (accept && (remaining == LAST_WORD)));

    // Accept words, count them down and issue each write one cycle after its accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            remaining <= '0;
            addr_next <= '0;
            imem_wea  <= 1'b0;
            imem_addr <= '0;
            imem_din  <= '0;
        end else begin
            imem_wea <= 1'b0;
            if (start) begin
                busy      <= 1'b1;
                remaining <= len;
                addr_next <= '0;
            end else if (busy) begin
                if (accept) begin
                    imem_wea  <= 1'b1;
                    imem_addr <= addr_next;
                    imem_din  <= ld_data;
                    addr_next <= addr_next + 1'b1;
                    remaining <= remaining - 1'b1;
                end
                if (done) begin
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/kgp_run_controller.sv
// rtl/kgp_run_controller.sv - boot/run sequencer for the single-cycle KGP core
module kgp_run_controller
    import kgp_ctrl_pkg::*;
#(
    parameter int AW         = 10,
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 4096
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          load_start,
    input  logic [AW:0]   load_len,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    output logic          ld_ready,
    input  logic          run,
    input  logic          step,
    input  logic          stop,
    input  logic [31:0]   pc_value,
    output logic          imem_wea,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_din,
    output logic          cpu_reset,
    output logic          cpu_ena,
    output logic          halted,
    output logic [1:0]    halt_cause,
    output logic [CW-1:0] cycle_count
);

    localparam logic [CW-1:0] WDOG_LAST = CW'(MAX_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    ctrl_state_t state, nxt;
    logic        load_go;
    logic        step_go;
    logic        ld_abort;
    logic        ld_done;
    logic [31:0] pc_prev;
    logic        pc_prev_valid;
    logic [1:0]  hit_cause;
    logic        hit;

    assign ld_abort = (state == ST_LOAD) && stop;

    kgp_imem_loader #(.AW(AW)) u_loader (
        .clk       (Clk),
        .reset     (Reset),
        .start     (load_go),
        .len       (load_len),
        .abort     (ld_abort),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .done      (ld_done),
        .imem_wea  (imem_wea),
        .imem_addr (imem_addr),
        .imem_din  (imem_din)
    );

    // Prioritised halt detection on the PC the core presents this cycle.
    always_comb begin
        hit_cause = HC_NONE;
        if (pc_value[31:AW] != '0) begin
            hit_cause = HC_RANGE;
        end else if (pc_prev_valid && (pc_value == pc_prev)) begin
            hit_cause = HC_SELF;
        end else if (cycle_count == WDOG_LAST) begin
            hit_cause = HC_WDOG;
        end
    end

    // Checks only matter on cycles where the core actually advanced.
    assign hit = cpu_ena && (hit_cause != HC_NONE);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state decode; a halt hit always beats stop/run/step.
    always_comb begin
        nxt     = state;
        load_go = 1'b0;
        step_go = 1'b0;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (load_start && (load_len != '0)) begin
                    nxt     = ST_LOAD;
                    load_go = 1'b1;
                end else if (run) begin
                    nxt = ST_CLEAR;
                end
            end
            ST_LOAD: begin
                if (ld_done) begin
                    nxt = ST_IDLE;
                end
            end
            ST_CLEAR: nxt = ST_RUN;
            ST_RUN: begin
                if (hit) begin
                    nxt = ST_HALT;
                end else if (stop) begin
                    nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (hit) begin
                    nxt = ST_HALT;
                end else if (run) begin
                    nxt = ST_RUN;
                end else if (step && !cpu_ena) begin
                    step_go = 1'b1;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Registered core controls, cycle counter and halt status.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cpu_reset     <= 1'b1;
            cpu_ena       <= 1'b0;
            halted        <= 1'b0;
            halt_cause    <= HC_NONE;
            cycle_count   <= '0;
            pc_prev       <= '0;
            pc_prev_valid <= 1'b0;
        end else begin
            // The core is held in reset while it is idle or being reprogrammed.
            cpu_reset <= (nxt == ST_IDLE) || (nxt == ST_LOAD) || (nxt == ST_CLEAR);
            cpu_ena   <= (nxt == ST_RUN) || step_go;
            halted    <= (nxt == ST_HALT);
            if (nxt == ST_CLEAR) begin
                cycle_count   <= '0;
                halt_cause    <= HC_NONE;
                pc_prev_valid <= 1'b0;
            end else if (cpu_ena) begin
                if (cycle_count != CNT_MAX) begin
                    cycle_count <= cycle_count + 1'b1;
                end
                pc_prev       <= pc_value;
                pc_prev_valid <= 1'b1;
                if (hit) begin
                    halt_cause <= hit_cause;
                end
            end
        end
    end

endmodule

// File: tb/tb_kgp_run_controller.sv
// tb/tb_kgp_run_controller.sv - scoreboard bench for the KGP run controller
module tb_kgp_run_controller;
    import kgp_ctrl_pkg::*;

    localparam int AW   = 10;
    localparam int CW   = 16;
    localparam int MAXC = 8;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          load_start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          ld_valid = 1'b0;
    logic [31:0]   ld_data = '0;
    logic          ld_ready;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic          stop = 1'b0;
    logic [31:0]   pc_value = '0;
    logic          imem_wea;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_din;
    logic          cpu_reset;
    logic          cpu_ena;
    logic          halted;
    logic [1:0]    halt_cause;
    logic [CW-1:0] cycle_count;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [1:0] cause; logic [CW-1:0] count; } hl_t;
    typedef struct { string name; logic [25:0] v; } snap_t;

    wr_t   wr_q[$];
    hl_t   hl_q[$];
    snap_t snap_q[$];

    int   pc3[5] = '{0, 1, 2, 3, 3};
    logic halted_d = 1'b0;

    kgp_run_controller #(.AW(AW), .CW(CW), .MAX_CYCLES(MAXC)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .load_start  (load_start),
        .load_len    (load_len),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .run         (run),
        .step        (step),
        .stop        (stop),
        .pc_value    (pc_value),
        .imem_wea    (imem_wea),
        .imem_addr   (imem_addr),
        .imem_din    (imem_din),
        .cpu_reset   (cpu_reset),
        .cpu_ena     (cpu_ena),
        .halted      (halted),
        .halt_cause  (halt_cause),
        .cycle_count (cycle_count)
    );

    always #5 Clk = ~Clk;

    // {state, cpu_reset, cpu_ena, ld_ready, imem_wea, halted, halt_cause, cycle_count}
    function automatic logic [25:0] sv(ctrl_state_t st, int rst, int ena, int rdy, int wea,
                                       int hl, int hc, int cnt);
        return {st, 1'(rst), 1'(ena), 1'(rdy), 1'(wea), 1'(hl), 2'(hc), 16'(cnt)};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic snap(input string name, input logic [25:0] v);
        snap_t s;
        s.name = name;
        s.v    = v;
        snap_q.push_back(s);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    // Snapshot monitor: compares queued expected status against the DUT mid-cycle.
    always @(negedge Clk) begin
        snap_t       s;
        logic [25:0] act;
        if (snap_q.size() != 0) begin
            s   = snap_q.pop_front();
            act = {dut.state, cpu_reset, cpu_ena, ld_ready, imem_wea, halted, halt_cause, cycle_count};
            n_cmp++;
            if (act !== s.v) begin
                n_fail++;
                $display("FAIL %s: got status %07h, required %07h", s.name, act, s.v);
            end
        end
    end

    // Write monitor: every instruction-memory write must match the next expected one.
    always @(negedge Clk) begin
        wr_t w;
        if (imem_wea) begin
            n_cmp++;
            if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got addr=%0h data=%08h, required no write", imem_addr, imem_din);
            end else begin
                w = wr_q.pop_front();
                if (imem_addr !== w.addr || imem_din !== w.data) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                             imem_addr, imem_din, w.addr, w.data);
                end
            end
        end
    end

    // Halt monitor: on each rising halted, check cause, count and that the core is frozen.
    always @(negedge Clk) begin
        hl_t h;
        if (halted && !halted_d) begin
            n_cmp++;
            if (hl_q.size() == 0) begin
                n_fail++;
                $display("FAIL halt_unexpected: got cause=%0d count=%0d, required no halt", halt_cause, cycle_count);
            end else begin
                h = hl_q.pop_front();
                if (halt_cause !== h.cause || cycle_count !== h.count || cpu_ena !== 1'b0) begin
                    n_fail++;
                    $display("FAIL halt: got cause=%0d count=%0d ena=%0b, required cause=%0d count=%0d ena=0",
                             halt_cause, cycle_count, cpu_ena, h.cause, h.count);
                end
            end
        end
        halted_d <= halted;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: got no end of stimulus, required completion");
        summary();
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        snap("reset", sv(ST_IDLE, 1, 0, 0, 0, 0, HC_NONE, 0));
        Reset = 1'b0;
        tick();

        // Four-word load with ld_valid held high.
        load_start = 1'b1; load_len = 11'd4;
        tick();
        load_start = 1'b0;
        snap("load_enter", sv(ST_LOAD, 1, 0, 1, 0, 0, HC_NONE, 0));
        for (int i = 0; i < 4; i++) begin
            wr_q.push_back('{addr: AW'(i), data: 32'(32'hA0 + i)});
            ld_valid = 1'b1;
            ld_data  = 32'(32'hA0 + i);
            tick();
        end
        ld_valid = 1'b0;
        snap("load_last_write", sv(ST_IDLE, 1, 0, 0, 1, 0, HC_NONE, 0));
        tick();
        snap("load_done", sv(ST_IDLE, 1, 0, 0, 0, 0, HC_NONE, 0));

        // Toggled ld_valid, abort after two accepts.
        load_start = 1'b1; load_len = 11'd8;
        tick();
        load_start = 1'b0;
        wr_q.push_back('{addr: AW'(0), data: 32'hB0});
        wr_q.push_back('{addr: AW'(1), data: 32'hB1});
        for (int i = 0; i < 4; i++) begin
            ld_valid = (i % 2 == 0);
            ld_data  = 32'(32'hB0 + i / 2);
            tick();
        end
        ld_valid = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        snap("load_abort", sv(ST_IDLE, 1, 0, 0, 0, 0, HC_NONE, 0));

        // ld_valid outside LOAD and a zero-length load are both ignored.
        ld_valid = 1'b1; ld_data = 32'hDEAD;
        repeat (2) tick();
        ld_valid = 1'b0;
        load_start = 1'b1; load_len = 11'd0;
        tick();
        load_start = 1'b0;
        snap("zero_len", sv(ST_IDLE, 1, 0, 0, 0, 0, HC_NONE, 0));

        // Run into a branch-to-self.
        run = 1'b1;
        tick();
        run = 1'b0;
        snap("clear", sv(ST_CLEAR, 1, 0, 0, 0, 0, HC_NONE, 0));
        tick();
        snap("run_enter", sv(ST_RUN, 0, 1, 0, 0, 0, HC_NONE, 0));
        hl_q.push_back('{cause: HC_SELF, count: 16'd5});
        for (int i = 0; i < 5; i++) begin
            pc_value = 32'(pc3[i]);
            tick();
        end
        snap("self_halt", sv(ST_HALT, 0, 0, 0, 0, 1, HC_SELF, 5));
        step = 1'b1; stop = 1'b1;
        tick();
        step = 1'b0; stop = 1'b0;
        snap("halt_ignore", sv(ST_HALT, 0, 0, 0, 0, 1, HC_SELF, 5));

        // Watchdog with incrementing PC, then restart clears the counter.
        run = 1'b1;
        tick();
        run = 1'b0;
        snap("clear2", sv(ST_CLEAR, 1, 0, 0, 0, 0, HC_NONE, 0));
        tick();
        hl_q.push_back('{cause: HC_WDOG, count: 16'd8});
        for (int i = 0; i < 8; i++) begin
            pc_value = 32'(i);
            tick();
        end
        snap("wdog_halt", sv(ST_HALT, 0, 0, 0, 0, 1, HC_WDOG, 8));
        run = 1'b1;
        tick();
        run = 1'b0;
        snap("clear3", sv(ST_CLEAR, 1, 0, 0, 0, 0, HC_NONE, 0));
        tick();
        snap("run_enter3", sv(ST_RUN, 0, 1, 0, 0, 0, HC_NONE, 0));

        // Pause, three single steps (first with step held two cycles), then resume.
        for (int i = 0; i < 3; i++) begin
            pc_value = 32'(100 + i);
            stop = (i == 2);
            tick();
        end
        stop = 1'b0;
        snap("pause", sv(ST_PAUSE, 0, 0, 0, 0, 0, HC_NONE, 3));
        for (int k = 0; k < 3; k++) begin
            pc_value = 32'(103 + k);
            step = 1'b1;
            tick();
            snap("step_on", sv(ST_PAUSE, 0, 1, 0, 0, 0, HC_NONE, 3 + k));
            if (k != 0) step = 1'b0;
            tick();
            step = 1'b0;
            snap("step_off", sv(ST_PAUSE, 0, 0, 0, 0, 0, HC_NONE, 4 + k));
        end
        run = 1'b1; step = 1'b1;
        tick();
        run = 1'b0; step = 1'b0;
        snap("resume", sv(ST_RUN, 0, 1, 0, 0, 0, HC_NONE, 6));
        hl_q.push_back('{cause: HC_WDOG, count: 16'd8});
        pc_value = 32'd106;
        tick();
        pc_value = 32'd107;
        tick();
        snap("resume_wdog", sv(ST_HALT, 0, 0, 0, 0, 1, HC_WDOG, 8));

        // Reset mid-RUN.
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        pc_value = 32'd200;
        tick();
        Reset = 1'b1;
        tick();
        snap("reset_run", sv(ST_IDLE, 1, 0, 0, 0, 0, HC_NONE, 0));
        Reset = 1'b0;
        tick();

        // Reset mid-LOAD with a word on the port: the write is dropped.
        load_start = 1'b1; load_len = 11'd4;
        tick();
        load_start = 1'b0;
        ld_valid = 1'b1; ld_data = 32'hC0; Reset = 1'b1;
        tick();
        snap("reset_load", sv(ST_IDLE, 1, 0, 0, 0, 0, HC_NONE, 0));
        Reset = 1'b0; ld_valid = 1'b0;
        tick();
        snap("after_reset_load", sv(ST_IDLE, 1, 0, 0, 0, 0, HC_NONE, 0));

        // PC out of range halts on the first enabled cycle.
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        hl_q.push_back('{cause: HC_RANGE, count: 16'd1});
        pc_value = 32'h400;
        tick();
        snap("range_halt", sv(ST_HALT, 0, 0, 0, 0, 1, HC_RANGE, 1));

        // Reload straight from HALT.
        load_start = 1'b1; load_len = 11'd1;
        tick();
        load_start = 1'b0;
        snap("halt_load", sv(ST_LOAD, 1, 0, 1, 0, 0, HC_RANGE, 1));
        wr_q.push_back('{addr: AW'(0), data: 32'hE5});
        ld_valid = 1'b1; ld_data = 32'hE5;
        tick();
        ld_valid = 1'b0;
        snap("halt_load_done", sv(ST_IDLE, 1, 0, 0, 1, 0, HC_RANGE, 1));
        repeat (3) tick();

        n_cmp++;
        if (wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL writes_pending: got %0d outstanding, required 0", wr_q.size());
        end
        n_cmp++;
        if (hl_q.size() != 0) begin
            n_fail++;
            $display("FAIL halts_pending: got %0d outstanding, required 0", hl_q.size());
        end
        n_cmp++;
        if (snap_q.size() != 0) begin
            n_fail++;
            $display("FAIL snaps_pending: got %0d outstanding, required 0", snap_q.size());
        end
        summary();
        $finish;
    end

endmodule
